// File: rtl/multi_port_write_back_pkg.sv
// Shared widths and the per-port selection record for the multi-port writeback stage.
// PERF_CNT_W sizes the optional WB_PERF_COUNTERS_EN counters.
package multi_port_write_back_pkg;

    localparam int NUM_WB_PORTS    = 2;
    localparam int NUM_WB_UNITS    = 4;
    localparam int WB_UNITS_WIDTH  = $clog2(NUM_WB_UNITS);
    localparam int IQ_DEPTH        = 8;
    localparam int IQ_INDEX_WIDTH  = $clog2(IQ_DEPTH);
    localparam int XLEN            = 32;
    localparam int ID_W            = 3;
    localparam int RD_W            = 5;
    localparam int PERF_CNT_W      = 32;

    typedef struct packed {
        logic                      valid;
        logic [WB_UNITS_WIDTH-1:0] unit_id;
        logic [ID_W-1:0]           id;
        logic [RD_W-1:0]           rd_addr;
        logic [IQ_INDEX_WIDTH-1:0] iq_index;
    } wb_select_t;

endpackage

// File: rtl/multi_port_write_back_wb_port_selector.sv
// Combinational age-ordered scan of the instruction queue, filling writeback ports 0,1,...
// Enforces one result per unit and no two writes to the same non-zero register per cycle.
module wb_port_selector
    import multi_port_write_back_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int N_UNITS = 4,
    parameter int DEPTH   = 8,
    parameter int CW      = $clog2(N_PORTS + 1)
) (
    input  logic                             inorder,
    input  logic [N_UNITS-1:0]               unit_early_done,
    input  logic [DEPTH-1:0]                 iq_valid,
    input  logic [DEPTH*WB_UNITS_WIDTH-1:0]  iq_unit_id,
    input  logic [DEPTH*ID_W-1:0]            iq_id,
    input  logic [DEPTH*RD_W-1:0]            iq_rd_addr,
    input  logic [DEPTH-1:0]                 iq_pop,
    output wb_select_t [N_PORTS-1:0]         sel,
    output logic [CW-1:0]                    sel_count
);

    always_comb begin
        logic [N_UNITS-1:0]        unit_used;
        logic [31:0]               rd_used;
        logic                      stop;
        logic [CW-1:0]             n;
        logic [WB_UNITS_WIDTH-1:0] u;
        logic [RD_W-1:0]           rd;
        logic                      take;

        sel       = '0;
        sel_count = '0;
        unit_used = '0;
        rd_used   = '0;
        stop      = 1'b0;
        n         = '0;
        u         = '0;
        rd        = '0;
        take      = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            u    = iq_unit_id[i*WB_UNITS_WIDTH +: WB_UNITS_WIDTH];
            rd   = iq_rd_addr[i*RD_W +: RD_W];
            take = unit_early_done[u] && !unit_used[u] && !((rd != '0) && rd_used[rd]);
            // Entries popped last cycle are still marked valid by the queue owner; skip them silently.
            if (iq_valid[i] && !iq_pop[i] && !stop && (n < CW'(N_PORTS))) begin
                if (take) begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        if (n == CW'(p)) begin
                            sel[p].valid    = 1'b1;
                            sel[p].unit_id  = u;
                            sel[p].id       = iq_id[i*ID_W +: ID_W];
                            sel[p].rd_addr  = rd;
                            sel[p].iq_index = IQ_INDEX_WIDTH'(i);
                        end
                    end
                    unit_used[u] = 1'b1;
                    if (rd != '0) begin
                        rd_used[rd] = 1'b1;
                    end
                    n = n + 1'b1;
                end else if (inorder) begin
                    stop = 1'b1;
                end
            end
        end
        sel_count = n;
    end

endmodule

// File: rtl/multi_port_write_back.sv
// Multi-port writeback: registers up to NUM_WB_PORTS retirements per cycle and muxes unit data.
// Optional WB_PERF_COUNTERS_EN adds perf_retired / perf_stall_cycles counters.
module multi_port_write_back
    import multi_port_write_back_pkg::*;
#(
    parameter int NUM_WB_PORTS = multi_port_write_back_pkg::NUM_WB_PORTS,
    parameter int NUM_WB_UNITS = multi_port_write_back_pkg::NUM_WB_UNITS,
    parameter int IQ_DEPTH     = multi_port_write_back_pkg::IQ_DEPTH,
    parameter int XLEN         = multi_port_write_back_pkg::XLEN,
    parameter int ID_W         = multi_port_write_back_pkg::ID_W
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      inorder,
    input  logic [NUM_WB_UNITS-1:0]                   unit_early_done,
    input  logic [NUM_WB_UNITS*XLEN-1:0]              unit_rd,
    output logic [NUM_WB_UNITS-1:0]                   unit_accepted,
    input  logic [IQ_DEPTH-1:0]                       iq_valid,
    input  logic [IQ_DEPTH*$clog2(NUM_WB_UNITS)-1:0]  iq_unit_id,
    input  logic [IQ_DEPTH*ID_W-1:0]                  iq_id,
    input  logic [IQ_DEPTH*5-1:0]                     iq_rd_addr,
    output logic [IQ_DEPTH-1:0]                       iq_pop,
    output logic [NUM_WB_PORTS-1:0]                   rf_valid,
    output logic [NUM_WB_PORTS*5-1:0]                 rf_rd_addr,
    output logic [NUM_WB_PORTS*ID_W-1:0]              rf_id,
    output logic [NUM_WB_PORTS*XLEN-1:0]              rf_data,
    output logic [$clog2(NUM_WB_PORTS+1)-1:0]         complete_count
`ifdef WB_PERF_COUNTERS_EN
    ,
    output logic [PERF_CNT_W-1:0]                     perf_retired,
    output logic [PERF_CNT_W-1:0]                     perf_stall_cycles
`endif
);

    localparam int UW = WB_UNITS_WIDTH;
    localparam int CW = $clog2(NUM_WB_PORTS + 1);

    wb_select_t [NUM_WB_PORTS-1:0]      sel;
    logic [CW-1:0]                      sel_count;
    logic [IQ_DEPTH-1:0]                pop_d;
    logic [NUM_WB_UNITS-1:0]            acc_d;
    logic [NUM_WB_PORTS-1:0]            port_valid_q;
    logic [NUM_WB_PORTS-1:0][UW-1:0]    port_unit_q;
    logic [NUM_WB_PORTS-1:0][ID_W-1:0]  port_id_q;
    logic [NUM_WB_PORTS-1:0][RD_W-1:0]  port_rd_q;

    wb_port_selector #(
        .N_PORTS (NUM_WB_PORTS),
        .N_UNITS (NUM_WB_UNITS),
        .DEPTH   (IQ_DEPTH),
        .CW      (CW)
    ) u_selector (
        .inorder         (inorder),
        .unit_early_done (unit_early_done),
        .iq_valid        (iq_valid),
        .iq_unit_id      (iq_unit_id),
        .iq_id           (iq_id),
        .iq_rd_addr      (iq_rd_addr),
        .iq_pop          (iq_pop),
        .sel             (sel),
        .sel_count       (sel_count)
    );

    always_comb begin
        pop_d = '0;
        acc_d = '0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (sel[p].valid) begin
                pop_d[sel[p].iq_index] = 1'b1;
                acc_d[sel[p].unit_id]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            port_valid_q   <= '0;
            port_unit_q    <= '0;
            port_id_q      <= '0;
            port_rd_q      <= '0;
            iq_pop         <= '0;
            unit_accepted  <= '0;
            complete_count <= '0;
        end else begin
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                port_valid_q[p] <= sel[p].valid;
                port_unit_q[p]  <= sel[p].unit_id;
                port_id_q[p]    <= sel[p].id;
                port_rd_q[p]    <= sel[p].rd_addr;
            end
            iq_pop         <= pop_d;
            unit_accepted  <= acc_d;
            complete_count <= sel_count;
        end
    end

    // Units hold their result until accepted, so data is read live in the write cycle.
    always_comb begin
        rf_valid   = port_valid_q;
        rf_rd_addr = '0;
        rf_id      = '0;
        rf_data    = '0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            rf_rd_addr[p*RD_W +: RD_W] = port_rd_q[p];
            rf_id[p*ID_W +: ID_W]      = port_id_q[p];
            for (int u = 0; u < NUM_WB_UNITS; u++) begin
                if (port_valid_q[p] && (port_unit_q[p] == UW'(u))) begin
                    rf_data[p*XLEN +: XLEN] = unit_rd[u*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef WB_PERF_COUNTERS_EN
    // A stall is a cycle with live (not just-popped) entries but nothing selected.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_retired      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_retired <= perf_retired + PERF_CNT_W'(complete_count);
            if ((|(iq_valid & ~iq_pop)) && (sel_count == '0)) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_port_write_back.sv
// Scoreboard bench for multi_port_write_back: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever the DUT shows any retirement activity.
module tb_multi_port_write_back;

    logic        clk;
    logic        rst;
    logic        inorder;
    logic [3:0]  unit_early_done;
    logic [127:0] unit_rd;
    logic [3:0]  unit_accepted;
    logic [7:0]  iq_valid;
    logic [15:0] iq_unit_id;
    logic [23:0] iq_id;
    logic [39:0] iq_rd_addr;
    logic [7:0]  iq_pop;
    logic [1:0]  rf_valid;
    logic [9:0]  rf_rd_addr;
    logic [5:0]  rf_id;
    logic [63:0] rf_data;
    logic [1:0]  complete_count;
`ifdef WB_PERF_COUNTERS_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_stall_cycles;
`endif

    multi_port_write_back dut (
        .clk             (clk),
        .rst             (rst),
        .inorder         (inorder),
        .unit_early_done (unit_early_done),
        .unit_rd         (unit_rd),
        .unit_accepted   (unit_accepted),
        .iq_valid        (iq_valid),
        .iq_unit_id      (iq_unit_id),
        .iq_id           (iq_id),
        .iq_rd_addr      (iq_rd_addr),
        .iq_pop          (iq_pop),
        .rf_valid        (rf_valid),
        .rf_rd_addr      (rf_rd_addr),
        .rf_id           (rf_id),
        .rf_data         (rf_data),
        .complete_count  (complete_count)
`ifdef WB_PERF_COUNTERS_EN
        ,
        .perf_retired      (perf_retired),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  valid;
        logic [9:0]  addr;
        logic [5:0]  id;
        logic [63:0] data;
        logic [7:0]  pop;
        logic [3:0]  acc;
        logic [1:0]  cnt;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rf_model [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_wb(input logic [1:0] v, input logic [9:0] a, input logic [5:0] id,
                             input logic [63:0] d, input logic [7:0] pop, input logic [3:0] acc,
                             input logic [1:0] cnt);
        exp_t e;
        e.valid = v; e.addr = a; e.id = id; e.data = d; e.pop = pop; e.acc = acc; e.cnt = cnt;
        sbq.push_back(e);
    endtask

    // Advance one cycle; inputs change just after the monitor's negedge sample.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_all();
        unit_early_done = '0;
        unit_rd         = '0;
        iq_valid        = '0;
        iq_unit_id      = '0;
        iq_id           = '0;
        iq_rd_addr      = '0;
    endtask

    task automatic set_entry(input int i, input int unit, input int id, input int rd);
        iq_valid[i]           = 1'b1;
        iq_unit_id[i*2 +: 2]  = 2'(unit);
        iq_id[i*3 +: 3]       = 3'(id);
        iq_rd_addr[i*5 +: 5]  = 5'(rd);
    endtask

    task automatic set_unit(input int u, input logic [31:0] d, input logic done);
        unit_rd[u*32 +: 32] = d;
        unit_early_done[u]  = done;
    endtask

    // Monitor: any retirement activity must match the oldest pending expectation.
    initial begin
        exp_t e;
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
        forever begin
            @(negedge clk);
            if (rst && (rf_valid != '0 || iq_pop != '0 || unit_accepted != '0 || complete_count != '0)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output rf_valid=%b iq_pop=%h accepted=%b count=%0d",
                             rf_valid, iq_pop, unit_accepted, complete_count);
                end else begin
                    e = sbq.pop_front();
                    check("rf_valid",       64'(rf_valid),       64'(e.valid));
                    check("rf_rd_addr",     64'(rf_rd_addr),     64'(e.addr));
                    check("rf_id",          64'(rf_id),          64'(e.id));
                    check("rf_data",        rf_data,             e.data);
                    check("iq_pop",         64'(iq_pop),         64'(e.pop));
                    check("unit_accepted",  64'(unit_accepted),  64'(e.acc));
                    check("complete_count", 64'(complete_count), 64'(e.cnt));
                end
                if (rf_valid[0]) rf_model[rf_rd_addr[4:0]] = rf_data[31:0];
                if (rf_valid[1]) rf_model[rf_rd_addr[9:5]] = rf_data[63:32];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, pending=%0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        inorder = 1'b1;
        clear_all();

        // Reset held with eligible work present
        set_entry(0, 0, 1, 5); set_unit(0, 32'h1111_1111, 1'b1);
        set_entry(1, 1, 2, 6); set_unit(1, 32'h2222_2222, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_iq_pop",         64'(iq_pop),         64'h0);
        check("reset_rf_valid",       64'(rf_valid),       64'h0);
        check("reset_complete_count", 64'(complete_count), 64'h0);
        check("reset_unit_accepted",  64'(unit_accepted),  64'h0);
        #1;
        clear_all();
        rst = 1'b1;

        // In-order, two done entries retire together
        inorder = 1'b1;
        set_entry(0, 0, 1, 5); set_unit(0, 32'hA000_0001, 1'b1);
        set_entry(1, 1, 2, 6); set_unit(1, 32'hB000_0002, 1'b1);
        expect_wb(2'b11, {5'd6, 5'd5}, {3'd2, 3'd1}, {32'hB000_0002, 32'hA000_0001},
                  8'h03, 4'b0011, 2'd2);
        cyc();
        clear_all();
        cyc();

        // In-order blocked by an older not-done entry, then released by out-of-order
        inorder = 1'b1;
        set_entry(0, 0, 7, 9);  set_unit(0, 32'h0, 1'b0);
        set_entry(1, 1, 3, 10); set_unit(1, 32'hC000_0003, 1'b1);
        cyc();
        cyc();
        check("inorder_block_rf_valid", 64'(rf_valid), 64'h0);
        check("inorder_block_iq_pop",   64'(iq_pop),   64'h0);
        inorder = 1'b0;
        expect_wb(2'b01, {5'd0, 5'd10}, {3'd0, 3'd3}, {32'd0, 32'hC000_0003},
                  8'h02, 4'b0010, 2'd1);
        cyc();
        clear_all();
        cyc();

        // Unit conflict: two entries on unit 2
        inorder = 1'b1;
        set_entry(0, 2, 3, 8);
        set_entry(1, 2, 4, 9);
        set_unit(2, 32'hD000_0000, 1'b1);
        expect_wb(2'b01, {5'd0, 5'd8}, {3'd0, 3'd3}, {32'd0, 32'hD000_0000},
                  8'h01, 4'b0100, 2'd1);
        cyc();
        iq_valid[0] = 1'b0;
        set_unit(2, 32'hD000_0001, 1'b1);
        expect_wb(2'b01, {5'd0, 5'd9}, {3'd0, 3'd4}, {32'd0, 32'hD000_0001},
                  8'h02, 4'b0100, 2'd1);
        cyc();
        clear_all();
        cyc();

        // Register conflict on x7, out-of-order
        inorder = 1'b0;
        set_entry(0, 0, 5, 7); set_unit(0, 32'hE000_0000, 1'b1);
        set_entry(2, 1, 6, 7); set_unit(1, 32'hE000_0002, 1'b1);
        expect_wb(2'b01, {5'd0, 5'd7}, {3'd0, 3'd5}, {32'd0, 32'hE000_0000},
                  8'h01, 4'b0001, 2'd1);
        cyc();
        iq_valid[0] = 1'b0;
        set_unit(0, 32'h0, 1'b0);
        expect_wb(2'b01, {5'd0, 5'd7}, {3'd0, 3'd6}, {32'd0, 32'hE000_0002},
                  8'h04, 4'b0010, 2'd1);
        cyc();
        clear_all();
        cyc();
        check("x7_final", 64'(rf_model[7]), 64'hE000_0002);

        // rd_addr 0 never conflicts and still writes
        inorder = 1'b1;
        set_entry(0, 0, 1, 0); set_unit(0, 32'hF000_0000, 1'b1);
        set_entry(1, 1, 2, 0); set_unit(1, 32'hF000_0001, 1'b1);
        expect_wb(2'b11, 10'd0, {3'd2, 3'd1}, {32'hF000_0001, 32'hF000_0000},
                  8'h03, 4'b0011, 2'd2);
        cyc();
        clear_all();
        cyc();

        // Three eligible entries with gaps: port limit pushes the third to the next cycle
        inorder = 1'b0;
        set_entry(1, 0, 1, 11); set_unit(0, 32'h6000_0001, 1'b1);
        set_entry(3, 1, 2, 12); set_unit(1, 32'h6000_0003, 1'b1);
        set_entry(5, 3, 3, 13); set_unit(3, 32'h6000_0005, 1'b1);
        expect_wb(2'b11, {5'd12, 5'd11}, {3'd2, 3'd1}, {32'h6000_0003, 32'h6000_0001},
                  8'h0A, 4'b0011, 2'd2);
        cyc();
        iq_valid[1] = 1'b0; iq_valid[3] = 1'b0;
        set_unit(0, 32'h0, 1'b0); set_unit(1, 32'h0, 1'b0);
        expect_wb(2'b01, {5'd0, 5'd13}, {3'd0, 3'd3}, {32'd0, 32'h6000_0005},
                  8'h20, 4'b1000, 2'd1);
        cyc();
        clear_all();
        cyc();

        // Full queue, nothing done
        inorder = 1'b0;
        for (int i = 0; i < 8; i++) set_entry(i, i % 4, i, i + 1);
        cyc();
        cyc();
        check("full_none_done_rf_valid", 64'(rf_valid),       64'h0);
        check("full_none_done_count",    64'(complete_count), 64'h0);
        clear_all();
        cyc();

`ifdef WB_PERF_COUNTERS_EN
        rst = 1'b0;
        cyc();
        cyc();
        rst     = 1'b1;
        inorder = 1'b1;
        set_entry(0, 0, 1, 3); set_unit(0, 32'h7000_0000, 1'b0);
        set_entry(1, 1, 2, 4); set_unit(1, 32'h7000_0001, 1'b0);
        repeat (10) cyc();
        set_unit(0, 32'h7000_0000, 1'b1);
        set_unit(1, 32'h7000_0001, 1'b1);
        expect_wb(2'b11, {5'd4, 5'd3}, {3'd2, 3'd1}, {32'h7000_0001, 32'h7000_0000},
                  8'h03, 4'b0011, 2'd2);
        cyc();
        clear_all();
        cyc();
        cyc();
        check("perf_stall_cycles", 64'(perf_stall_cycles), 64'd10);
        check("perf_retired",      64'(perf_retired),      64'd2);
`endif

        cyc();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_port_write_back.md
Name: multi_port_write_back

Overview:
- Parametrised successor to the single-port writeback stage.
- Retires up to NUM_WB_PORTS completed instructions per cycle from the instruction queue to the register file.
- Selects in-order or out-of-order via the `inorder` input; resolves unit and destination-register conflicts.
- Sits between the functional-unit writeback outputs and the register file / ID generator.

Parameters:
- NUM_WB_PORTS, 2, register-file write ports driven per cycle (1..4)
- NUM_WB_UNITS, 4, functional units presenting results
- IQ_DEPTH, 8, instruction-queue entries; entry 0 is oldest
- XLEN, 32, data width
- ID_W, 3, instruction-id width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- inorder  in  1  1: retire strictly in age order; 0: retire oldest done entries in any order
- unit_early_done  in  NUM_WB_UNITS  unit result available next cycle
- unit_rd  in  NUM_WB_UNITS*XLEN  unit result data, held until accepted
- unit_accepted  out  NUM_WB_UNITS  unit result consumed
- iq_valid  in  IQ_DEPTH  entry occupied
- iq_unit_id  in  IQ_DEPTH*clog2(NUM_WB_UNITS)  producing unit per entry
- iq_id  in  IQ_DEPTH*ID_W  instruction id per entry
- iq_rd_addr  in  IQ_DEPTH*5  destination register per entry
- iq_pop  out  IQ_DEPTH  entry retired
- rf_valid  out  NUM_WB_PORTS  write enable per port
- rf_rd_addr  out  NUM_WB_PORTS*5  write address per port
- rf_id  out  NUM_WB_PORTS*ID_W  id per port
- rf_data  out  NUM_WB_PORTS*XLEN  write data per port
- complete_count  out  clog2(NUM_WB_PORTS+1)  retirements this cycle, to ID generator

Behaviour:
- Reset (rst==0 at posedge): iq_pop, unit_accepted, rf_valid, complete_count = 0; selection registers cleared.
- Eligible entry: iq_valid[i] & ~iq_pop[i] & unit_early_done[iq_unit_id[i]]. Entries popped last cycle are excluded.
- Selection (combinational, cycle N): scan entries 0..IQ_DEPTH-1 and assign eligible entries to ports 0,1,... in age order, up to NUM_WB_PORTS.
  - Skip an entry whose unit is already selected this cycle (one result per unit per cycle).
  - Skip an entry whose rd_addr (non-zero) matches an older selected entry; it retries next cycle.
  - inorder=1: scanning stops at the first valid, non-popped entry that is not eligible or is skipped.
  - inorder=0: scanning continues past it.
- Registered at posedge N+1: iq_pop[i] for each selected i; unit_accepted[u] for each selected unit; per-port unit_id, id, rd_addr; rf_valid[p]; complete_count = number selected.
- Cycle N+1 outputs:
  - rf_data[p] = unit_rd[registered unit_id of port p], combinational read.
  - Latency: early_done to rf write is 1 cycle.
- Unused ports: rf_valid=0, other fields 0.
- rd_addr 0 writes still retire and pop with rf_valid=1; the register file ignores x0.
- Queue empty (all iq_valid=0): no selection, all outputs idle.
- Queue full with no eligible entries: no selection.
- inorder toggled mid-stream: takes effect on the next selection; anything already registered completes.
- Reset mid-operation: registered selections are dropped; the queue owner must also flush.

Optional Feature:
- WB_PERF_COUNTERS_EN.
- Defined: adds outputs perf_retired (32 bits) and perf_stall_cycles (32 bits).
  - perf_retired accumulates complete_count.
  - perf_stall_cycles increments when any entry is valid and none is selected.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists.

Decomposition:
- Shared package (riscv_config/riscv_types): NUM_WB_PORTS, WB_UNITS_WIDTH, the wb_select_t struct {valid, unit_id, id, rd_addr, iq_index}, and the perf counter width.
- One sub-module, wb_port_selector: combinational priority scan producing NUM_WB_PORTS wb_select_t.
- Top level holds the registers, unit_rd muxing and counters.

Test Plan:
- Setup for all: NUM_WB_PORTS=2 unless stated.
- Reset: hold rst=0 for 2 cycles with entries valid and done -> iq_pop=0, rf_valid=0, complete_count=0.
- In-order, entries 0,1 done on units 0,1 (rd 5,6) -> next cycle rf_valid=2'b11, rf_rd_addr={6,5}, iq_pop=8'h03, complete_count=2.
- In-order, entry 0 not done, entry 1 done -> no retirement. Switch inorder=0 -> entry 1 retires on port 0, iq_pop=8'h02.
- Unit conflict: entries 0,1 both on unit 2, both eligible -> cycle 1 retires entry 0 only. Entry 1 retires the cycle after (unit re-asserts early_done).
- Register conflict: entries 0,2 both target x7, out-of-order, both done -> entry 0 writes first. Entry 2 writes the following cycle; final x7 holds entry 2 data.
- WB_PERF_COUNTERS_EN: 10 cycles with a valid, not-done entry, then a 2-wide retirement -> perf_stall_cycles=10, perf_retired=2.
